// File: rtl/pwm_pkg.sv
// Shared PWM datapath package: sizing helpers and pipeline limits.
// Exports clog2, max1, PIPE_MAX_DEPTH and PIPE_MAX_WIDTH.
package pwm_pkg;

  localparam int PIPE_MAX_DEPTH = 16;
  localparam int PIPE_MAX_WIDTH = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One enabled data+valid register with sync reset and valid clear.
// Ports: ck, rst, en, clr, d, d_vld -> q, q_vld.
module pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  // clr drops the valid bit only; data is kept
  always_ff @(posedge ck) begin
    if (rst) begin
      q     <= RST_VAL;
      q_vld <= 1'b0;
    end else if (clr) begin
      q_vld <= 1'b0;
    end else if (en) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// WIDTH x DEPTH delay line with enable, valid tracking, flush and tap.
// Ports: ck, rst, en, flush, d, d_vld, tap_sel -> q, q_vld, q_tap, tap_vld, fill_cnt.
module reg_pipe
  import pwm_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               TW      = max1(clog2(DEPTH)),
  parameter int               CW      = clog2(DEPTH + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [WIDTH-1:0] q_tap,
  output logic             tap_vld,
  output logic [CW-1:0]    fill_cnt
);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("reg_pipe: DEPTH out of range");
  end
  if (WIDTH < 1 || WIDTH > PIPE_MAX_WIDTH) begin : g_bad_width
    $error("reg_pipe: WIDTH out of range");
  end

  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    fill_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic [WIDTH-1:0] din;
    logic             vin;
    if (i == 0) begin : g_head
      assign din = d;
      assign vin = d_vld;
    end else begin : g_tail
      assign din = dat[i-1];
      assign vin = vld[i-1];
    end
    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stg (
      .ck    (ck),
      .rst   (rst),
      .en    (en),
      .clr   (flush),
      .d     (din),
      .d_vld (vin),
      .q     (dat[i]),
      .q_vld (vld[i])
    );
  end

  // one word in, one word out per advance
  always_comb begin
    fill_d = fill_q;
    if (en) begin
      fill_d = fill_q + CW'(d_vld) - CW'(vld[DEPTH-1]);
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      fill_q <= '0;
    end else if (flush) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  if (DEPTH == 1) begin : g_tap1
    assign q_tap   = dat[0];
    assign tap_vld = vld[0];
  end else begin : g_tapn
    // out-of-range selects fall through to the reset value
    always_comb begin
      q_tap   = RST_VAL;
      tap_vld = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (tap_sel == TW'(i)) begin
          q_tap   = dat[i];
          tap_vld = vld[i];
        end
      end
    end
  end

  assign q        = dat[DEPTH-1];
  assign q_vld    = vld[DEPTH-1];
  assign fill_cnt = fill_q;

  a_fill : assert property (
    @(posedge ck) disable iff (rst)
    int'(fill_q) == $countones(vld)
  ) else $error("reg_pipe: fill count out of step with valids");

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: DEPTH=4 instance with scoreboard on q,
// plus a DEPTH=3 instance for the non-power-of-2 tap and saturation.
module tb_reg_pipe;

  logic       ck;
  logic       rst;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic       d_vld;

  logic [1:0] tap_sel;
  logic [7:0] q;
  logic       q_vld;
  logic [7:0] q_tap;
  logic       tap_vld;
  logic [2:0] fill;

  logic [1:0] tap_sel3;
  logic [7:0] q3;
  logic       q3_vld;
  logic [7:0] q_tap3;
  logic       tap3_vld;
  logic [1:0] fill3;

  int nvec;
  int nerr;
  logic [7:0] sb [$];

  reg_pipe #(.WIDTH(8), .DEPTH(4)) u4 (
    .ck       (ck),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .d        (d),
    .d_vld    (d_vld),
    .tap_sel  (tap_sel),
    .q        (q),
    .q_vld    (q_vld),
    .q_tap    (q_tap),
    .tap_vld  (tap_vld),
    .fill_cnt (fill)
  );

  reg_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h5A)) u3 (
    .ck       (ck),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .d        (d),
    .d_vld    (d_vld),
    .tap_sel  (tap_sel3),
    .q        (q3),
    .q_vld    (q3_vld),
    .q_tap    (q_tap3),
    .tap_vld  (tap3_vld),
    .fill_cnt (fill3)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive on negedge, return 1 time unit after the next posedge
  task automatic step(input logic r, input logic e, input logic f,
                      input logic [7:0] dd, input logic dv);
    @(negedge ck);
    rst   = r;
    en    = e;
    flush = f;
    d     = dd;
    d_vld = dv;
    if (r || f) sb.delete();
    else if (e && dv) sb.push_back(dd);
    @(posedge ck);
    #1;
  endtask

  // monitor: one pop per enabled edge that delivers a valid word
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge ck);
      #1;
      if (en && !flush && !rst && q_vld) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL sb_unexpected: got %0h expected none", q);
        end else begin
          e = sb.pop_front();
          chk("sb_q", {24'd0, q}, {24'd0, e});
        end
      end
    end
  end

  logic [2:0] f1 [6];
  logic [2:0] f3 [8];
  logic       v3 [4];

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1; en = 1'b0; flush = 1'b0;
    d = 8'h00; d_vld = 1'b0;
    tap_sel = 2'd0; tap_sel3 = 2'd0;
    f1 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    f3 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0};
    v3 = '{1'b1, 1'b0, 1'b1, 1'b1};

    // 1: reset then steady stream
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_qvld", {31'd0, q_vld}, 32'd0);
    chk("rst_tapvld", {31'd0, tap_vld}, 32'd0);
    chk("rst_fill", {29'd0, fill}, 32'd0);
    chk("rst_q3", {24'd0, q3}, 32'h5A);
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 8'h10 + 8'(k), 1);
      chk("t1_fill", {29'd0, fill}, {29'd0, f1[k]});
      if (k == 2) chk("t1_qvld_early", {31'd0, q_vld}, 32'd0);
      if (k == 3) begin
        chk("t1_qvld_lat", {31'd0, q_vld}, 32'd1);
        chk("t1_q_lat", {24'd0, q}, 32'h10);
      end
    end

    // 2: stall
    for (int k = 0; k < 4; k++) step(0, 1, 0, 8'hA0 + 8'(k), 1);
    chk("t2_q_full", {24'd0, q}, 32'hA0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 8'hEE, 1);
      chk("t2_q_stall", {24'd0, q}, 32'hA0);
      chk("t2_fill_stall", {29'd0, fill}, 32'd4);
    end
    step(0, 1, 0, 8'h00, 0);
    chk("t2_q_resume", {24'd0, q}, 32'hA1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 8'h00, 0);
    chk("t2_fill_drained", {29'd0, fill}, 32'd0);

    // 3: bubbles
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, (k < 4) ? 8'h01 + 8'(k) : 8'h00,
           (k < 4) ? v3[k] : 1'b0);
      chk("t3_fill", {29'd0, fill}, {29'd0, f3[k]});
      if (k >= 3 && k <= 6)
        chk("t3_qvld", {31'd0, q_vld}, {31'd0, v3[k-3]});
      if (k == 4) chk("t3_q_bubble_data", {24'd0, q}, 32'h02);
    end

    // 4: flush with a simultaneous valid input
    step(0, 1, 0, 8'h53, 1);
    step(0, 1, 0, 8'h54, 1);
    step(0, 1, 0, 8'h56, 1);
    step(0, 1, 0, 8'h57, 1);
    step(0, 1, 1, 8'h55, 1);
    chk("t4_fill", {29'd0, fill}, 32'd0);
    chk("t4_qvld", {31'd0, q_vld}, 32'd0);
    chk("t4_q_kept", {24'd0, q}, 32'h53);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 8'h00, 0);
      chk("t4_qvld_after", {31'd0, q_vld}, 32'd0);
      chk("t4_no55", {31'd0, q == 8'h55}, 32'd0);
      if (k == 0) chk("t4_q_shift", {24'd0, q}, 32'h54);
    end

    // 5: reset mid-operation, then tap
    step(0, 1, 0, 8'h70, 1);
    step(0, 1, 0, 8'h71, 1);
    step(1, 1, 1, 8'h77, 1);
    chk("t5_q", {24'd0, q}, 32'h00);
    chk("t5_qvld", {31'd0, q_vld}, 32'd0);
    chk("t5_fill", {29'd0, fill}, 32'd0);
    chk("t5_q3", {24'd0, q3}, 32'h5A);
    chk("t5_fill3", {30'd0, fill3}, 32'd0);
    for (int t = 0; t < 4; t++) begin
      tap_sel = 2'(t);
      #1;
      chk("t5_tap_data", {24'd0, q_tap}, 32'h00);
      chk("t5_tap_vld", {31'd0, tap_vld}, 32'd0);
    end
    tap_sel = 2'd1;
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 8'h20 + 8'(k), 1);
      if (k == 1) begin
        chk("t5_tap1", {24'd0, q_tap}, 32'h20);
        chk("t5_tap1_vld", {31'd0, tap_vld}, 32'd1);
        tap_sel = 2'd0;
        #1;
        chk("t5_tap0", {24'd0, q_tap}, 32'h21);
        tap_sel = 2'd1;
      end
      // 6: DEPTH=3 build saturates at 3
      if (k >= 2) chk("t6_fill3", {30'd0, fill3}, 32'd3);
    end
    chk("t6_q3", {24'd0, q3}, 32'h23);
    tap_sel3 = 2'd3;
    #1;
    chk("t6_tap3_oob", {24'd0, q_tap3}, 32'h5A);
    chk("t6_tap3_oob_vld", {31'd0, tap3_vld}, 32'd0);
    tap_sel3 = 2'd1;
    #1;
    chk("t6_tap3_1", {24'd0, q_tap3}, 32'h24);
    chk("t6_tap3_1_vld", {31'd0, tap3_vld}, 32'd1);

    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'h00, 0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
